// File: rtl/rv32_regfile_sb_if.sv
// rv32_regfile_sb_if: read, issue, writeback and flush bundle for the scoreboarded register file
interface rv32_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
);
    logic [NRP*AW-1:0]   rp_addr_i;
    logic [NRP*XLEN-1:0] rp_data_o;
    logic [NRP-1:0]      rp_busy_o;
    logic                iss_v_i;
    logic [AW-1:0]       iss_rd_i;
    logic                iss_rdy_o;
    logic                wb0_v_i;
    logic [AW-1:0]       wb0_addr_i;
    logic [XLEN-1:0]     wb0_data_i;
    logic                wb1_v_i;
    logic [AW-1:0]       wb1_addr_i;
    logic [XLEN-1:0]     wb1_data_i;
    logic                flush_i;
    logic [AW:0]         pend_cnt_o;

    modport slave (
        input  rp_addr_i, iss_v_i, iss_rd_i, wb0_v_i, wb0_addr_i, wb0_data_i,
               wb1_v_i, wb1_addr_i, wb1_data_i, flush_i,
        output rp_data_o, rp_busy_o, iss_rdy_o, pend_cnt_o
    );

    modport master (
        output rp_addr_i, iss_v_i, iss_rd_i, wb0_v_i, wb0_addr_i, wb0_data_i,
               wb1_v_i, wb1_addr_i, wb1_data_i, flush_i,
        input  rp_data_o, rp_busy_o, iss_rdy_o, pend_cnt_o
    );
endinterface

// File: rtl/rv32_regfile_sb.sv
// rv32_regfile_sb: register file with writeback bypass and a per-register busy scoreboard
module rv32_regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input logic              clk_i,
    input logic              rst_n_i,
    rv32_regfile_sb_if.slave bus
);
    localparam int NREG = 2**AW;

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [AW:0]               pend_q, pend_d;
    logic                      wb0_hit, wb1_hit, iss_acc, inc, clr0, clr1;

    assign wb0_hit = bus.wb0_v_i && bus.wb0_addr_i != '0;
    assign wb1_hit = bus.wb1_v_i && bus.wb1_addr_i != '0;

    assign bus.iss_rdy_o = !busy_q[bus.iss_rd_i] || bus.iss_rd_i == '0
                         || (wb0_hit && bus.wb0_addr_i == bus.iss_rd_i)
                         || (wb1_hit && bus.wb1_addr_i == bus.iss_rd_i);
    assign iss_acc = bus.iss_v_i && bus.iss_rdy_o && bus.iss_rd_i != '0 && !bus.flush_i;
    assign bus.pend_cnt_o = pend_q;

    always_comb begin
        regs_d = regs_q;
        if (wb0_hit) regs_d[bus.wb0_addr_i] = bus.wb0_data_i;
        if (wb1_hit) regs_d[bus.wb1_addr_i] = bus.wb1_data_i;
        regs_d[0] = '0;
        busy_d = busy_q;
        if (wb0_hit) busy_d[bus.wb0_addr_i] = 1'b0;
        if (wb1_hit) busy_d[bus.wb1_addr_i] = 1'b0;
        if (iss_acc) busy_d[bus.iss_rd_i] = 1'b1;
        if (bus.flush_i) busy_d = '0;
        busy_d[0] = 1'b0;
        // count only bits that really flip; a clear re-set by the issue is no change
        inc  = iss_acc && !busy_q[bus.iss_rd_i];
        clr0 = wb0_hit && busy_q[bus.wb0_addr_i] && !(iss_acc && bus.iss_rd_i == bus.wb0_addr_i);
        clr1 = wb1_hit && busy_q[bus.wb1_addr_i] && !(iss_acc && bus.iss_rd_i == bus.wb1_addr_i)
             && !(wb0_hit && bus.wb0_addr_i == bus.wb1_addr_i);
        pend_d = bus.flush_i ? '0 : pend_q + (AW+1)'(inc) - (AW+1)'(clr0) - (AW+1)'(clr1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '0;
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rp
        logic [AW-1:0] a;
        logic          hit0, hit1;
        assign a    = bus.rp_addr_i[k*AW +: AW];
        assign hit0 = wb0_hit && bus.wb0_addr_i == a;
        assign hit1 = wb1_hit && bus.wb1_addr_i == a;
        assign bus.rp_data_o[k*XLEN +: XLEN] = (!rst_n_i || a == '0) ? '0
                                             : hit1 ? bus.wb1_data_i
                                             : hit0 ? bus.wb0_data_i
                                             : regs_q[a];
        assign bus.rp_busy_o[k] = busy_q[a] && !hit0 && !hit1;
    end
endmodule
